// File: rtl/union_1.sv
// union_1: temperature monitor with fan/alarm thresholds and a 4-digit multiplexed 7-segment display.
// Optional macro UNION_1_HYST_EN adds 3-degree turn-off hysteresis to the fan and alarm outputs.
module union_1 #(
    parameter int REFRESH_DIV = 1024,
    parameter int FAN_ON      = 25,
    parameter int ALARM_ON    = 30
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [4:0] temperatura,
    input  logic       en_m1,
    input  logic       lect,
    output logic       est_alarma,
    output logic       est_ventilador,
    output logic [3:0] anodos,
    output logic [7:0] catodos
);
    logic [4:0]  temp_reg, disp_reg;
    logic [15:0] cnt;
    logic [1:0]  idx;
    logic        act, fan_nx, alarm_nx, wrap;
    logic [1:0]  tens;
    logic [3:0]  units;
    logic [7:0]  status, digit;

    function automatic logic [7:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    return 8'hC0;
            4'd1:    return 8'hF9;
            4'd2:    return 8'hA4;
            4'd3:    return 8'hB0;
            4'd4:    return 8'h99;
            4'd5:    return 8'h92;
            4'd6:    return 8'h82;
            4'd7:    return 8'hF8;
            4'd8:    return 8'h80;
            4'd9:    return 8'h90;
            default: return 8'hFF;
        endcase
    endfunction

    always_comb begin
`ifdef UNION_1_HYST_EN
        fan_nx   = est_ventilador ? (int'(temp_reg) > FAN_ON - 3) : (int'(temp_reg) >= FAN_ON);
        alarm_nx = est_alarma ? (int'(temp_reg) > ALARM_ON - 3) : (int'(temp_reg) >= ALARM_ON);
`else
        fan_nx   = int'(temp_reg) >= FAN_ON;
        alarm_nx = int'(temp_reg) >= ALARM_ON;
`endif
        wrap   = cnt == 16'(REFRESH_DIV - 1);
        tens   = disp_reg >= 5'd30 ? 2'd3 : disp_reg >= 5'd20 ? 2'd2 : disp_reg >= 5'd10 ? 2'd1 : 2'd0;
        units  = 4'(disp_reg - 5'(tens) * 5'd10);
        status = est_alarma ? 8'h88 : est_ventilador ? 8'h8E : 8'hFF;
        digit  = idx == 2'd0 ? seg7(units) : idx == 2'd1 ? seg7({2'b00, tens}) : idx == 2'd2 ? 8'hFF : status;
        anodos  = act ? ~(4'b0001 << idx) : 4'hF;
        catodos = act ? digit : 8'hFF;
    end

    // act delays en_m1 by one edge so the display blanks on the edge after disable and stays dark in reset
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            temp_reg       <= '0;
            disp_reg       <= '0;
            cnt            <= '0;
            idx            <= '0;
            act            <= 1'b0;
            est_ventilador <= 1'b0;
            est_alarma     <= 1'b0;
        end else begin
            temp_reg       <= en_m1 ? temperatura : temp_reg;
            disp_reg       <= lect ? disp_reg : temp_reg;
            cnt            <= wrap ? '0 : cnt + 16'd1;
            idx            <= idx + {1'b0, wrap};
            act            <= en_m1;
            est_ventilador <= en_m1 & fan_nx;
            est_alarma     <= en_m1 & alarm_nx;
        end
    end
endmodule

// File: tb/tb_union_1.sv
// tb_union_1: scoreboard bench for union_1; a cycle-level reference model queues expected outputs
// and a negedge monitor compares them against the DUT.
module tb_union_1;
    localparam int DIV = 4, FAN = 25, ALM = 30;

    logic       clock = 1'b0, reset = 1'b0;
    logic [4:0] temperatura = '0;
    logic       en_m1 = 1'b0, lect = 1'b0;
    logic       est_alarma, est_ventilador;
    logic [3:0] anodos;
    logic [7:0] catodos;

    typedef struct {
        logic       a;
        logic       f;
        logic [3:0] an;
        logic [7:0] ca;
    } exp_t;

    exp_t q[$];
    int compared = 0, mismatched = 0;
    logic [7:0] segs[10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
    int   m_temp, m_disp, m_cyc;
    logic m_fan, m_alarm, m_on;

    union_1 #(.REFRESH_DIV(DIV), .FAN_ON(FAN), .ALARM_ON(ALM)) dut (
        .clock(clock), .reset(reset), .temperatura(temperatura), .en_m1(en_m1), .lect(lect),
        .est_alarma(est_alarma), .est_ventilador(est_ventilador), .anodos(anodos), .catodos(catodos)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    function automatic logic thr(input logic prev, input int t, input int on);
`ifdef UNION_1_HYST_EN
        return prev ? (t > on - 3) : (t >= on);
`else
        return t >= on;
`endif
    endfunction

    task automatic model_reset();
        m_temp = 0; m_disp = 0; m_cyc = 0;
        m_fan = 0; m_alarm = 0; m_on = 0;
    endtask

    task automatic step(input int t, input logic e, input logic l);
        exp_t ex;
        int   idx;
        logic nf, na;
        temperatura = 5'(t);
        en_m1 = e;
        lect = l;
        @(posedge clock);
        nf = e && thr(m_fan, m_temp, FAN);
        na = e && thr(m_alarm, m_temp, ALM);
        m_disp  = l ? m_disp : m_temp;
        m_temp  = e ? t : m_temp;
        m_fan   = nf;
        m_alarm = na;
        m_on    = e;
        m_cyc++;
        idx   = (m_cyc / DIV) % 4;
        ex.a  = m_alarm;
        ex.f  = m_fan;
        ex.an = m_on ? 4'hF & ~(4'b0001 << idx) : 4'hF;
        if (!m_on) ex.ca = 8'hFF;
        else if (idx == 0) ex.ca = segs[m_disp % 10];
        else if (idx == 1) ex.ca = segs[m_disp / 10];
        else if (idx == 2) ex.ca = 8'hFF;
        else ex.ca = m_alarm ? 8'h88 : m_fan ? 8'h8E : 8'hFF;
        q.push_back(ex);
        #2;
    endtask

    task automatic do_reset();
        @(negedge clock);
        #1 reset = 1'b0;
        #1;
        check("rst_alarma", {7'b0, est_alarma}, 8'h00);
        check("rst_ventilador", {7'b0, est_ventilador}, 8'h00);
        check("rst_anodos", {4'b0, anodos}, 8'h0F);
        check("rst_catodos", catodos, 8'hFF);
        repeat (2) @(posedge clock);
        @(negedge clock);
        #1 reset = 1'b1;
        model_reset();
    endtask

    always @(negedge clock) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            check("est_alarma", {7'b0, est_alarma}, {7'b0, e.a});
            check("est_ventilador", {7'b0, est_ventilador}, {7'b0, e.f});
            check("anodos", {4'b0, anodos}, {4'b0, e.an});
            check("catodos", catodos, e.ca);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        int seq[5] = '{10, 20, 25, 28, 30};
        int hyst[3] = '{25, 23, 22};
        int t, rep;
        logic e, l;
        model_reset();
        #3;
        check("init_alarma", {7'b0, est_alarma}, 8'h00);
        check("init_ventilador", {7'b0, est_ventilador}, 8'h00);
        check("init_anodos", {4'b0, anodos}, 8'h0F);
        check("init_catodos", catodos, 8'hFF);
        @(negedge clock);
        #1 reset = 1'b1;
        repeat (3) step(0, 0, 0);
        foreach (seq[i]) repeat (50) step(seq[i], 1, 0);
        repeat (16) step(28, 1, 0);
        repeat (10) step(30, 1, 0);
        repeat (5) step(30, 1, 1);
        repeat (20) step(10, 1, 1);
        repeat (5) step(10, 1, 0);
        foreach (hyst[i]) repeat (10) step(hyst[i], 1, 0);
        repeat (10) step(31, 1, 0);
        repeat (5) step(31, 0, 0);
        repeat (10) step(31, 1, 0);
        repeat (3) step(27, 1, 0);
        do_reset();
        repeat (10) step(31, 1, 0);
        for (int k = 0; k < 300; k++) begin
            t   = $urandom_range(0, 31);
            e   = $urandom_range(0, 9) != 0;
            l   = $urandom_range(0, 3) == 0;
            rep = $urandom_range(1, 8);
            repeat (rep) step(t, e, l);
            if (k == 150) do_reset();
        end
        repeat (2) @(negedge clock);
        #1;
        compared++;
        if (q.size() != 0) begin
            mismatched++;
            $display("FAIL drain: %0d expected entries left, required 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
